ctrl_ramdrv_ringbuf_mc: RTL and testbench

Multi-channel ring buffer address generator for the sample RAM driver. It keeps one circular sample segment per channel, defined by a base pointer, a last pointer and a head pointer. New-sample pushes advance the channel head with wrap-around. A read sweep is a start/busy/done sequence that emits a programmable number of tap addresses, newest-first or oldest-first. It sits between the controller FSM and the RAM address mux and generalises the single-channel ring counter in channel count, sweep length and direction.

---
 rtl/ctrl_ramdrv_ringbuf_mc.sv | 140 ++++++++++++++
 tb/tb_ctrl_ramdrv_ringbuf_mc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_ramdrv_ringbuf_mc.sv
// Multi-channel ring buffer address generator for the sample RAM driver.
// Tracks per-channel circular segments, emits push write addresses and tap read sweeps.
module ctrl_ramdrv_ringbuf_mc #(
  parameter int ADDR_WIDTH = 12,
  parameter int CHANNELS   = 2,
  parameter int CH_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cfg_we,
  input  logic [CH_WIDTH-1:0]   cfg_ch,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  input  logic                  push,
  input  logic [CH_WIDTH-1:0]   push_ch,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   start_ch,
  input  logic [ADDR_WIDTH-1:0] sweep_len,
  input  logic                  sweep_dir,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_r [CHANNELS];
  logic [ADDR_WIDTH-1:0] last_r [CHANNELS];
  logic [ADDR_WIDTH-1:0] head_r [CHANNELS];
  logic [CH_WIDTH-1:0]   ch_q;
  logic                  dir_q;
  logic [LW-1:0]         cnt;

  logic                  cfg_ok, push_ok, start_ok, err_next;
  logic [ADDR_WIDTH-1:0] head_next, rd_step, first_addr;
  logic [ADDR_WIDTH-1:0] s_base, s_last, s_head;
  logic [LW-1:0]         seg_len, req_len, len, off;

  always_comb begin
    cfg_ok   = cfg_we && (int'(cfg_ch) < CHANNELS) && (cfg_base <= cfg_last)
               && !((state == SWEEP) && (cfg_ch == ch_q));
    push_ok  = push && (int'(push_ch) < CHANNELS) && !(cfg_we && (cfg_ch == push_ch));
    start_ok = start && (int'(start_ch) < CHANNELS) && (state != SWEEP);
    err_next = (cfg_we && !cfg_ok) || (push && !push_ok) || (start && !start_ok);

    head_next = (head_r[push_ch] == last_r[push_ch]) ? base_r[push_ch]
                                                     : head_r[push_ch] + ADDR_WIDTH'(1);

    // Snapshot uses register values before this edge, so a same-cycle push is not seen.
    s_base  = base_r[start_ch];
    s_last  = last_r[start_ch];
    s_head  = head_r[start_ch];
    seg_len = {1'b0, s_last} - {1'b0, s_base} + LW'(1);
    req_len = {1'b0, sweep_len};
    len     = (req_len < seg_len) ? req_len : seg_len;
    off     = {1'b0, s_head - s_base};
    if (!sweep_dir)
      first_addr = s_head;
    else if (off >= len - LW'(1))
      first_addr = s_head - ADDR_WIDTH'(len - LW'(1));
    else
      first_addr = s_last - ADDR_WIDTH'(len - LW'(2) - off);

    if (dir_q)
      rd_step = (rd_addr == last_r[ch_q]) ? base_r[ch_q] : rd_addr + ADDR_WIDTH'(1);
    else
      rd_step = (rd_addr == base_r[ch_q]) ? last_r[ch_q] : rd_addr - ADDR_WIDTH'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start_ok) state_next = (len == '0) ? DONE : SWEEP;
      end
      SWEEP:   if (cnt == LW'(1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state == SWEEP);
  assign rd_valid = (state == SWEEP);
  assign done     = (state == DONE);

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      ch_q     <= '0;
      dir_q    <= 1'b0;
      cnt      <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_valid <= 1'b0;
      err      <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        base_r[c] <= '0;
        last_r[c] <= '0;
        head_r[c] <= '0;
      end
    end else begin
      state    <= state_next;
      wr_valid <= push_ok;
      err      <= err_next;
      if (push_ok) wr_addr <= head_next;

      case (state)
        IDLE, DONE: if (start_ok) begin
          ch_q  <= start_ch;
          dir_q <= sweep_dir;
          cnt   <= len;
          if (len != '0) rd_addr <= first_addr;
        end
        SWEEP: if (cnt != LW'(1)) begin
          rd_addr <= rd_step;
          cnt     <= cnt - LW'(1);
        end
        default: ;
      endcase

      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (cfg_ok && (cfg_ch == CH_WIDTH'(c))) begin
          base_r[c] <= cfg_base;
          last_r[c] <= cfg_last;
          head_r[c] <= cfg_base;
        end else if (push_ok && (push_ch == CH_WIDTH'(c))) begin
          head_r[c] <= head_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_ramdrv_ringbuf_mc.sv
// Directed self-checking bench for ctrl_ramdrv_ringbuf_mc.
// DUT updates on the falling edge; outputs are checked 1 time unit after it.
module tb_ctrl_ramdrv_ringbuf_mc;

  logic        clk = 1'b0;
  logic        clr;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [11:0] cfg_base, cfg_last;
  logic        push;
  logic [0:0]  push_ch;
  logic        start;
  logic [0:0]  start_ch;
  logic [11:0] sweep_len;
  logic        sweep_dir;
  logic [11:0] wr_addr, rd_addr;
  logic        wr_valid, rd_valid, busy, done, err;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_rd [8];

  ctrl_ramdrv_ringbuf_mc #(.ADDR_WIDTH(12), .CHANNELS(2), .CH_WIDTH(1)) dut (
    .clk(clk), .clr(clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_last(cfg_last),
    .push(push), .push_ch(push_ch),
    .start(start), .start_ch(start_ch), .sweep_len(sweep_len), .sweep_dir(sweep_dir),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_wr_valid"}, wr_valid, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
  endtask

  // Sweep on ch0 expecting n addresses from exp_rd, then one done pulse.
  task automatic do_sweep(input logic [11:0] len, input logic dir, input int n);
    start = 1'b1; start_ch = 1'b0; sweep_len = len; sweep_dir = dir;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_b("sw_rd_valid", rd_valid, 1'b1);
      chk_b("sw_busy", busy, 1'b1);
      chk_a("sw_rd_addr", rd_addr, exp_rd[i]);
      tick();
    end
    chk_b("sw_done", done, 1'b1);
    chk_b("sw_done_busy", busy, 1'b0);
    chk_b("sw_done_rd_valid", rd_valid, 1'b0);
    tick();
    chk_b("sw_done_pulse", done, 1'b0);
  endtask

  initial begin
    clr = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_last = '0;
    push = 1'b0; push_ch = '0; start = 1'b0; start_ch = '0;
    sweep_len = '0; sweep_dir = 1'b0;
    #2;
    chk_idle_outs("rst");
    chk_a("rst_wr_addr", wr_addr, 12'h000);
    chk_a("rst_rd_addr", rd_addr, 12'h000);
    tick();
    clr = 1'b0;

    // 1: configure ch0 and push four samples
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_base = 12'h010; cfg_last = 12'h013;
    tick();
    cfg_we = 1'b0;
    chk_b("cfg0_err", err, 1'b0);
    exp_rd[0] = 12'h011; exp_rd[1] = 12'h012; exp_rd[2] = 12'h013; exp_rd[3] = 12'h010;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_ch = 1'b0;
      tick();
      push = 1'b0;
      chk_b("push_wr_valid", wr_valid, 1'b1);
      chk_a("push_wr_addr", wr_addr, exp_rd[i]);
      tick();
      chk_b("push_pulse", wr_valid, 1'b0);
      chk_a("push_hold", wr_addr, exp_rd[i]);
    end

    // 2/3: sweeps on ch0 with head=0x010
    exp_rd[0] = 12'h010; exp_rd[1] = 12'h013; exp_rd[2] = 12'h012; exp_rd[3] = 12'h011;
    do_sweep(12'd4, 1'b0, 4);
    exp_rd[0] = 12'h012; exp_rd[1] = 12'h013; exp_rd[2] = 12'h010;
    do_sweep(12'd3, 1'b1, 3);
    exp_rd[0] = 12'h011; exp_rd[1] = 12'h012; exp_rd[2] = 12'h013; exp_rd[3] = 12'h010;
    do_sweep(12'd4, 1'b1, 4);
    exp_rd[0] = 12'h010; exp_rd[1] = 12'h013; exp_rd[2] = 12'h012; exp_rd[3] = 12'h011;
    do_sweep(12'd9, 1'b0, 4);
    do_sweep(12'd0, 1'b0, 0);
    chk_a("len0_rd_hold", rd_addr, 12'h011);

    // 4: sweep with concurrent pushes, second start rejected
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_base = 12'h100; cfg_last = 12'h107;
    tick();
    cfg_we = 1'b0;
    chk_b("cfg1_err", err, 1'b0);
    start = 1'b1; start_ch = 1'b0; sweep_len = 12'd4; sweep_dir = 1'b0;
    push = 1'b1; push_ch = 1'b0;
    tick();
    start = 1'b0; push_ch = 1'b1;
    chk_a("c4_rd0", rd_addr, 12'h010);
    chk_a("c4_wr0", wr_addr, 12'h011);
    chk_b("c4_err0", err, 1'b0);
    tick();
    push_ch = 1'b0; start = 1'b1; start_ch = 1'b1;
    chk_a("c4_rd1", rd_addr, 12'h013);
    chk_a("c4_wr1", wr_addr, 12'h101);
    chk_b("c4_err1", err, 1'b0);
    tick();
    start = 1'b0; push_ch = 1'b1;
    chk_a("c4_rd2", rd_addr, 12'h012);
    chk_a("c4_wr2", wr_addr, 12'h012);
    chk_b("c4_err_start", err, 1'b1);
    chk_b("c4_busy2", busy, 1'b1);
    tick();
    push = 1'b0;
    chk_a("c4_rd3", rd_addr, 12'h011);
    chk_a("c4_wr3", wr_addr, 12'h102);
    chk_b("c4_err3", err, 1'b0);
    tick();
    chk_b("c4_done", done, 1'b1);
    chk_b("c4_done_busy", busy, 1'b0);
    tick();

    // 5: bad config rejected; cfg+push collision on ch1
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_base = 12'h020; cfg_last = 12'h01F;
    tick();
    cfg_we = 1'b0;
    chk_b("badcfg_err", err, 1'b1);
    push = 1'b1; push_ch = 1'b0;
    tick();
    chk_b("badcfg_err_pulse", err, 1'b0);
    chk_a("badcfg_keep_a", wr_addr, 12'h013);
    tick();
    push = 1'b0;
    chk_a("badcfg_keep_wrap", wr_addr, 12'h010);
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_base = 12'h200; cfg_last = 12'h203;
    push = 1'b1; push_ch = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk_b("coll_err", err, 1'b1);
    chk_b("coll_wr_valid", wr_valid, 1'b0);
    tick();
    push = 1'b0;
    chk_a("coll_head_base", wr_addr, 12'h201);
    chk_b("coll_after_err", err, 1'b0);

    // 6: asynchronous reset mid-sweep
    start = 1'b1; start_ch = 1'b1; sweep_len = 12'd4; sweep_dir = 1'b0;
    push = 1'b1; push_ch = 1'b0;
    tick();
    start = 1'b0; push = 1'b0;
    chk_b("pre_clr_busy", busy, 1'b1);
    chk_b("pre_clr_wr_valid", wr_valid, 1'b1);
    #2 clr = 1'b1;
    #1;
    chk_idle_outs("clr");
    #1 clr = 1'b0;
    tick();
    chk_b("post_clr_done", done, 1'b0);
    start = 1'b1; start_ch = 1'b0; sweep_len = 12'd5; sweep_dir = 1'b0;
    push = 1'b1; push_ch = 1'b1;
    tick();
    start = 1'b0; push = 1'b0;
    chk_b("post_clr_rd_valid", rd_valid, 1'b1);
    chk_a("post_clr_rd_addr", rd_addr, 12'h000);
    chk_b("post_clr_wr_valid", wr_valid, 1'b1);
    chk_a("post_clr_wr_addr", wr_addr, 12'h000);
    tick();
    chk_b("post_clr_len1_done", done, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
